// File: rtl/foc_deadlock_report_tx.sv
// ---------------------------------------------------------------------------
// foc_deadlock_report_tx
//
// Purpose:
//   Watches per-channel block flags coming from deadlock monitors. A channel
//   is "confirmed" once its flag has been high for PERSIST consecutive
//   cycles. Each confirmation queues a one-beat AXI-Stream report that
//   carries the channel number and a 16-bit cycle timestamp taken at the
//   confirming edge. If a channel confirms again while its previous report
//   is still queued, the new event is dropped and a sticky overflow bit is
//   raised for that channel.
//
// Ports:
//   clock          in   single clock, rising edge
//   reset          in   synchronous, active-high reset
//   block_in       in   [NUM_CH]  per-channel block flags (bit i = channel i)
//   clear_ovf      in   single-cycle pulse, clears all overflow bits
//   m_axis_tdata   out  [32] report word {8'hDB, 3'b000, ch[4:0], stamp}
//   m_axis_tvalid  out  report word valid
//   m_axis_tready  in   downstream accepts the word
//   m_axis_tlast   out  end of report (every report is a single beat)
//   any_block      out  registered OR of all confirmed channels
//   overflow       out  [NUM_CH] sticky per-channel lost-report flags
//
// Parameters:
//   NUM_CH   number of monitored channels (1..32)
//   PERSIST  consecutive high cycles needed to confirm (2..65535)
// ---------------------------------------------------------------------------
module foc_deadlock_report_tx #(
  parameter int NUM_CH  = 8,
  parameter int PERSIST = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] block_in,
  input  logic              clear_ovf,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              any_block,
  output logic [NUM_CH-1:0] overflow
);

  localparam int          IDXW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [15:0] PERSIST_V  = 16'(PERSIST);
  localparam logic [15:0] PERSIST_M1 = 16'(PERSIST - 1);
  localparam logic [7:0]  TAG        = 8'hDB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Free-running timestamp
  // -------------------------------------------------------------------------
  logic [15:0] ts_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 16'd1;  // wraps naturally at 0xFFFF
    end
  end

  // -------------------------------------------------------------------------
  // Transmit-side state shared with the per-channel logic
  // -------------------------------------------------------------------------
  state_e                    state_q;
  logic [IDXW-1:0]           sel_q;
  logic [31:0]               tdata_q;
  logic                      tvalid_q;
  logic                      tlast_q;
  logic                      hs;

  logic [NUM_CH-1:0]         pending_q;
  logic [NUM_CH-1:0]         overflow_q;
  logic [NUM_CH-1:0]         confirmed;
  logic [NUM_CH-1:0][15:0]   stamp_all;

  // A report leaves the block only on a handshake in SEND.
  assign hs = (state_q == SEND) && tvalid_q && m_axis_tready;

  // -------------------------------------------------------------------------
  // Per-channel persistence counter, pending/overflow flags and timestamp
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        pend_q;
    logic        pend_d;
    logic        ovf_q;
    logic        ovf_d;
    logic [15:0] stamp_q;
    logic        confirm_evt;
    logic        hs_clr;
    logic        pend_after_clr;

    always_comb begin
      if (!block_in[gi]) begin
        cnt_d = '0;
      end else if (cnt_q == PERSIST_V) begin
        cnt_d = cnt_q;  // saturate so one high run yields one event
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    // Event fires only on the PERSIST-1 -> PERSIST step.
    assign confirm_evt = block_in[gi] && (cnt_q == PERSIST_M1);
    assign hs_clr      = hs && (sel_q == IDXW'(gi));

    // The in-flight report is retired before a same-edge confirm is looked
    // at, so a confirm during the handshake re-queues rather than overflows.
    assign pend_after_clr = pend_q & ~hs_clr;

    always_comb begin
      pend_d = pend_after_clr;
      ovf_d  = ovf_q & ~clear_ovf;
      if (confirm_evt) begin
        if (pend_after_clr) begin
          ovf_d = 1'b1;  // set beats a coincident clear
        end else begin
          pend_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        ovf_q   <= 1'b0;
        stamp_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        pend_q <= pend_d;
        ovf_q  <= ovf_d;
        if (confirm_evt && !pend_after_clr) begin
          stamp_q <= ts_q;
        end
      end
    end

    assign confirmed[gi]  = (cnt_q == PERSIST_V);
    assign pending_q[gi]  = pend_q;
    assign overflow_q[gi] = ovf_q;
    assign stamp_all[gi]  = stamp_q;
  end

  // -------------------------------------------------------------------------
  // Confirmed summary flag
  // -------------------------------------------------------------------------
  logic any_block_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      any_block_q <= 1'b0;
    end else begin
      any_block_q <= |confirmed;
    end
  end

  // -------------------------------------------------------------------------
  // Lowest-index pending channel (fixed priority, no round-robin)
  // -------------------------------------------------------------------------
  logic [IDXW-1:0] sel_idx;

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_idx = IDXW'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Transmit FSM: IDLE picks a channel, LOAD builds the word, SEND holds it
  // until accepted. tdata is forced to zero whenever tvalid is low.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pending_q) begin
            sel_q   <= sel_idx;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          // pending[sel] stays set until the handshake, so stamp[sel] is
          // frozen from here on and the word cannot go stale.
          tdata_q  <= {TAG, 3'b000, 5'(sel_q), stamp_all[sel_q]};
          tvalid_q <= 1'b1;
          tlast_q  <= 1'b1;
          state_q  <= SEND;
        end
        SEND: begin
          if (m_axis_tready) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          tdata_q  <= '0;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign any_block     = any_block_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_foc_deadlock_report_tx.sv
// ---------------------------------------------------------------------------
// tb_foc_deadlock_report_tx
//
// Self-checking bench for foc_deadlock_report_tx (NUM_CH=8, PERSIST=4).
// Expected report words are pushed to a queue when the stimulus that should
// produce them is driven; a monitor pops and compares on each handshake.
// Cycle numbering: "cycle k" is the clock period during which the
// timestamp counter holds k; inputs are driven and outputs sampled 1 time
// unit after the rising edge, and the monitor samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_foc_deadlock_report_tx;

  localparam int NUM_CH  = 8;
  localparam int PERSIST = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] block_in = '0;
  logic              clear_ovf = 1'b0;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;
  logic              any_block;
  logic [NUM_CH-1:0] overflow;

  foc_deadlock_report_tx #(
    .NUM_CH (NUM_CH),
    .PERSIST(PERSIST)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .block_in     (block_in),
    .clear_ovf    (clear_ovf),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .any_block    (any_block),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  // Reference cycle counter: 0 in the first cycle after reset release.
  logic [15:0] tb_ts = 16'd0;
  always @(posedge clock) tb_ts <= reset ? 16'd0 : tb_ts + 16'd1;

  int          checks   = 0;
  int          failures = 0;
  int          rx_count = 0;
  logic [15:0] last_hs_ts = 16'd0;
  logic [15:0] prev_hs_ts = 16'd0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] rpt(input int ch, input logic [15:0] st);
    return {8'hDB, 3'b000, 5'(ch), st};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard consumer: runs for the whole simulation.
  task automatic monitor_loop;
    logic [31:0] exp;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (!m_axis_tvalid) begin
          checks++;
          if (m_axis_tdata !== 32'h0) begin
            failures++;
            $display("FAIL idle_tdata cycle=%0d got=%h expected=00000000", tb_ts, m_axis_tdata);
          end
        end else if (m_axis_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_report cycle=%0d got=%h expected=none", tb_ts, m_axis_tdata);
          end else begin
            exp = exp_q.pop_front();
            if (m_axis_tdata !== exp) begin
              failures++;
              $display("FAIL report_data cycle=%0d got=%h expected=%h", tb_ts, m_axis_tdata, exp);
            end
          end
          checks++;
          if (m_axis_tlast !== 1'b1) begin
            failures++;
            $display("FAIL report_tlast cycle=%0d got=%b expected=1", tb_ts, m_axis_tlast);
          end
          $display("report cycle=%0d tdata=%h", tb_ts, m_axis_tdata);
          rx_count++;
          prev_hs_ts = last_hs_ts;
          last_hs_ts = tb_ts;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset;
    reset    = 1'b1;
    block_in = '1;  // must be ignored while reset is high
    tick();
    tick();
    tick();
    checks++;
    if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b expected=0", m_axis_tvalid); end
    checks++;
    if (m_axis_tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata got=%h expected=00000000", m_axis_tdata); end
    checks++;
    if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b expected=0", m_axis_tlast); end
    checks++;
    if (any_block !== 1'b0) begin failures++; $display("FAIL reset_any_block got=%b expected=0", any_block); end
    checks++;
    if (overflow !== '0) begin failures++; $display("FAIL reset_overflow got=%h expected=00", overflow); end
    // Channel 0 stays high across release: counting starts at cycle 0.
    block_in = 8'h01;
    reset    = 1'b0;
    exp_q.push_back(rpt(0, 16'd3));
    for (int k = 0; k < 12; k++) begin
      block_in[0] = (k <= 5);
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL reset_release_drain got=%0d expected=0", exp_q.size()); end
    checks++;
    if (last_hs_ts !== 16'd6) begin failures++; $display("FAIL reset_release_hs_cycle got=%0d expected=6", last_hs_ts); end
    $display("test_reset done");
  endtask

  // ---------------------------------------------------------------------
  task automatic test_basic;
    block_in = '0;
    do_reset();
    while (tb_ts != 16'd10) tick();
    for (int k = 10; k <= 25; k++) begin
      if (k == 10) exp_q.push_back(32'hDB03000D);
      block_in[3] = (k >= 10 && k <= 20);
      checks++;
      if (any_block !== ((k >= 15 && k <= 22) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL basic_any_block cycle=%0d got=%b expected=%b", k, any_block, (k >= 15 && k <= 22));
      end
      checks++;
      if (m_axis_tvalid !== ((k == 16) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL basic_tvalid cycle=%0d got=%b expected=%b", k, m_axis_tvalid, (k == 16));
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL basic_drain got=%0d expected=0", exp_q.size()); end
    checks++;
    if (overflow !== '0) begin failures++; $display("FAIL basic_overflow got=%h expected=00", overflow); end
    $display("test_basic done");
  endtask

  // ---------------------------------------------------------------------
  task automatic test_glitch;
    int rx0;
    logic [11:0] pat;
    rx0 = rx_count;
    pat = 12'b0000_0111_0111;  // LSB first: 3 high, 1 low, 3 high
    for (int k = 0; k < 12; k++) begin
      block_in[5] = pat[k];
      checks++;
      if (any_block !== 1'b0) begin failures++; $display("FAIL glitch_any_block step=%0d got=%b expected=0", k, any_block); end
      tick();
    end
    block_in[5] = 1'b0;
    tick();
    tick();
    checks++;
    if (overflow !== '0) begin failures++; $display("FAIL glitch_overflow got=%h expected=00", overflow); end
    checks++;
    if (rx_count != rx0) begin failures++; $display("FAIL glitch_reports got=%0d expected=%0d", rx_count, rx0); end
    $display("test_glitch done");
  endtask

  // ---------------------------------------------------------------------
  task automatic test_overflow;
    int          rx0;
    logic [15:0] s2;
    logic [15:0] s4;
    rx0 = rx_count;
    m_axis_tready = 1'b0;
    s2 = tb_ts + 16'd3;
    exp_q.push_back(rpt(2, s2));
    block_in[2] = 1'b1;
    repeat (4) tick();
    block_in[2] = 1'b0;
    tick();
    block_in[2] = 1'b1;
    repeat (4) tick();
    block_in[2] = 1'b0;
    checks++;
    if (overflow !== 8'h04) begin failures++; $display("FAIL ovf_set got=%h expected=04", overflow); end
    checks++;
    if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL ovf_stall_tvalid got=%b expected=1", m_axis_tvalid); end
    checks++;
    if (m_axis_tdata !== rpt(2, s2)) begin failures++; $display("FAIL ovf_stall_tdata got=%h expected=%h", m_axis_tdata, rpt(2, s2)); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++;
    if (overflow !== 8'h00) begin failures++; $display("FAIL ovf_clear got=%h expected=00", overflow); end
    // Second confirm of ch4 coincides with a clear pulse: the set must win.
    s4 = tb_ts + 16'd3;
    exp_q.push_back(rpt(4, s4));
    block_in[4] = 1'b1;
    repeat (4) tick();
    block_in[4] = 1'b0;
    tick();
    block_in[4] = 1'b1;
    repeat (3) tick();
    clear_ovf = 1'b1;
    tick();
    clear_ovf   = 1'b0;
    block_in[4] = 1'b0;
    checks++;
    if (overflow !== 8'h10) begin failures++; $display("FAIL ovf_set_wins got=%h expected=10", overflow); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    m_axis_tready = 1'b1;
    for (int n = 0; n < 30 && exp_q.size() != 0; n++) tick();
    repeat (6) tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_drain got=%0d expected=0", exp_q.size()); end
    checks++;
    if (rx_count != rx0 + 2) begin failures++; $display("FAIL ovf_report_count got=%0d expected=%0d", rx_count - rx0, 2); end
    checks++;
    if (overflow !== 8'h00) begin failures++; $display("FAIL ovf_final got=%h expected=00", overflow); end
    $display("test_overflow done");
  endtask

  // ---------------------------------------------------------------------
  task automatic test_priority;
    logic [15:0] c;
    c = tb_ts;
    exp_q.push_back(rpt(1, c + 16'd3));
    exp_q.push_back(rpt(6, c + 16'd3));
    for (int k = 0; k < 14; k++) begin
      block_in[1] = (k < 5);
      block_in[6] = (k < 5);
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL prio_drain got=%0d expected=0", exp_q.size()); end
    checks++;
    if (prev_hs_ts !== c + 16'd6) begin failures++; $display("FAIL prio_first_hs got=%0d expected=%0d", prev_hs_ts, c + 16'd6); end
    checks++;
    if (last_hs_ts - prev_hs_ts !== 16'd3) begin failures++; $display("FAIL prio_spacing got=%0d expected=3", last_hs_ts - prev_hs_ts); end
    $display("test_priority done");
  endtask

  // ---------------------------------------------------------------------
  task automatic test_back_to_back_reconfirm;
    logic [15:0] a;
    a = tb_ts;
    m_axis_tready = 1'b0;
    exp_q.push_back(rpt(0, a + 16'd3));
    block_in[0] = 1'b1;
    repeat (4) tick();
    block_in[0] = 1'b0;
    repeat (2) tick();
    block_in[0] = 1'b1;
    repeat (3) tick();
    // Cycle a+9: handshake and re-confirm share this edge.
    m_axis_tready = 1'b1;
    exp_q.push_back(rpt(0, a + 16'd9));
    tick();
    block_in[0] = 1'b0;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL reconfirm_drain got=%0d expected=0", exp_q.size()); end
    checks++;
    if (overflow !== 8'h00) begin failures++; $display("FAIL reconfirm_overflow got=%h expected=00", overflow); end
    $display("test_back_to_back_reconfirm done");
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset_mid_send;
    int rx0;
    rx0 = rx_count;
    m_axis_tready = 1'b0;
    block_in[7] = 1'b1;
    repeat (4) tick();
    block_in[7] = 1'b0;
    for (int n = 0; n < 10 && !m_axis_tvalid; n++) tick();
    checks++;
    if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL midsend_tvalid_up got=%b expected=1", m_axis_tvalid); end
    reset = 1'b1;
    tick();
    checks++;
    if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL midsend_tvalid_drop got=%b expected=0", m_axis_tvalid); end
    reset = 1'b0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL midsend_resend step=%0d got=%b expected=0", k, m_axis_tvalid); end
      tick();
    end
    checks++;
    if (rx_count != rx0) begin failures++; $display("FAIL midsend_reports got=%0d expected=%0d", rx_count, rx0); end
    $display("test_reset_mid_send done");
  endtask

  // ---------------------------------------------------------------------
  task automatic test_wrap;
    block_in = '0;
    do_reset();
    while (tb_ts != 16'hFFFC) tick();
    exp_q.push_back(rpt(4, 16'hFFFF));
    block_in[4] = 1'b1;
    tick();
    exp_q.push_back(rpt(5, 16'h0000));  // confirms one edge after the wrap
    block_in[5] = 1'b1;
    repeat (5) tick();
    block_in = '0;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_drain got=%0d expected=0", exp_q.size()); end
    $display("test_wrap done");
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_basic();
    test_glitch();
    test_overflow();
    test_priority();
    test_back_to_back_reconfirm();
    test_reset_mid_send();
    test_wrap();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
